// File: rtl/lpdaq_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lpdaq_arb_pkg
//  Purpose  : Shared types and helpers for the LPDAQ AXI-Stream arbiter:
//             arbiter state encoding and channel-index width function.
//  Revision : 1.0 - initial release
// ============================================================================
package lpdaq_arb_pkg;

    // Arbiter control states: waiting for a request, or forwarding one channel
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Bits needed to hold a channel index (at least one bit)
    function automatic int ch_idx_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lpdaq_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : lpdaq_rr_pick
//  Purpose  : Combinational round-robin picker. Searches the request mask
//             starting one position after i_last, wrapping at NUM_CH-1 -> 0,
//             and returns the first requesting index plus a valid flag.
//  Revision : 1.0 - initial release
// ============================================================================
module lpdaq_rr_pick
    import lpdaq_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IW     = ch_idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IW-1:0]     i_last,
    output logic [IW-1:0]     o_idx,
    output logic              o_valid
);

    logic [IW-1:0] w_cand;

    // Walk candidates from the farthest to the nearest so the nearest
    // requester after i_last is the one left in o_idx.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        w_cand  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_cand = IW'((int'(i_last) + k) % NUM_CH);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lpdaq_axis_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lpdaq_axis_arbiter
//  Purpose  : Round-robin N:1 AXI-Stream arbiter for the LPDAQ acquisition
//             path. One channel is granted at a time and forwarded
//             combinationally; a grant ends on a tlast beat (source tlast or
//             the MAX_BEATS quota), followed by one idle bubble cycle.
//  Options  : LPDAQ_ARB_TIMEOUT_EN - when defined, a granted channel that
//             stays invalid for TIMEOUT consecutive cycles is released and
//             timeout_pulse strobes for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module lpdaq_axis_arbiter
    import lpdaq_arb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 24,
    parameter int MAX_BEATS  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    input  logic [NUM_CH-1:0]            s_axis_tlast,
    output logic [NUM_CH-1:0]            s_axis_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]            ch_en,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [$clog2(NUM_CH)-1:0]    m_axis_tid,
    output logic                         grant_active,
    output logic                         timeout_pulse
);

    localparam int         c_IW        = ch_idx_width(NUM_CH);
    localparam logic [7:0] c_LAST_BEAT = 8'(MAX_BEATS - 1);

    arb_state_t             r_state;
    logic [c_IW-1:0]        r_grant;
    logic [c_IW-1:0]        r_last_grant;
    logic [7:0]             r_beat_cnt;

    logic [NUM_CH-1:0]      w_req;
    logic [c_IW-1:0]        w_pick_idx;
    logic                   w_pick_valid;
    logic [DATA_WIDTH-1:0]  w_data_arr [NUM_CH];
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic                   w_in_grant;
    logic                   w_hs;
    logic                   w_last;
    logic                   w_timeout;
    logic                   w_release;

    // Split the flat sample bus into one word per channel
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign w_data_arr[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_req       = ch_en & s_axis_tvalid;
    assign w_in_grant  = (r_state == ST_GRANT);
    assign w_sel_valid = s_axis_tvalid[r_grant];
    assign w_sel_last  = s_axis_tlast[r_grant];
    assign w_last      = w_sel_last | (r_beat_cnt == c_LAST_BEAT);
    assign w_hs        = w_in_grant & w_sel_valid & m_axis_tready;
    assign w_release   = (w_hs & w_last) | w_timeout;

    lpdaq_rr_pick #(
        .NUM_CH (NUM_CH),
        .IW     (c_IW)
    ) u_rr_pick (
        .i_req   (w_req),
        .i_last  (r_last_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Arbitration FSM: pick a channel in IDLE, count beats and release in GRANT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_IW'(NUM_CH - 1);
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state    <= ST_GRANT;
                        r_grant    <= w_pick_idx;
                        r_beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_grant;
                    end else if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LPDAQ_ARB_TIMEOUT_EN
    localparam int c_STALL_W = $clog2(TIMEOUT + 1);

    logic [c_STALL_W-1:0] r_stall;
    logic                 r_timeout_pulse;

    assign w_timeout = w_in_grant & ~w_sel_valid &
                       (r_stall == c_STALL_W'(TIMEOUT - 1));

    // Stall counter: consecutive granted cycles without a valid source beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall         <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_timeout;
            if (!w_in_grant || w_sel_valid || w_timeout) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign timeout_pulse = r_timeout_pulse;
`else
    assign w_timeout     = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // Output mux: forward the granted channel, everything quiet in IDLE
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tid    = '0;
        s_axis_tready = '0;
        if (w_in_grant) begin
            m_axis_tvalid          = w_sel_valid;
            m_axis_tlast           = w_last;
            m_axis_tdata           = w_data_arr[r_grant];
            m_axis_tid             = r_grant;
            s_axis_tready[r_grant] = m_axis_tready;
        end
    end

    assign grant_active = w_in_grant;

endmodule
`default_nettype wire
